// File: rtl/multicycle_mips_ctrl.sv
// Multicycle control FSM for a shared-memory MIPS datapath: sequences fetch,
// decode, memory and writeback phases and counts retired instructions.
module multicycle_mips_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_control,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        instr_done,
   output logic        illegal_op,
   output logic [31:0] instr_count,
   output logic [3:0]  state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   function automatic logic funct_ok(input logic [5:0] f);
      logic ok;
      case (f)
         F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
         default:                          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] alu_from_funct(input logic [5:0] f);
      logic [3:0] op;
      case (f)
         F_SUB:   op = ALU_SUB;
         F_AND:   op = ALU_AND;
         F_OR:    op = ALU_OR;
         F_SLT:   op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   logic [3:0]  state_r;
   logic [3:0]  next_state;
   logic [31:0] count_r;

   logic        iord_c, mem_read_c, mem_write_c, ir_write_c, pc_en_c;
   logic [1:0]  pc_src_c, alu_src_b_c;
   logic        alu_src_a_c, reg_dst_c, mem_to_reg_c, reg_write_c;
   logic [3:0]  alu_control_c;
   logic        done_c, illegal_c;

   // Next-state and output decode; everything defaults to 0 and each state raises its own controls
   always_comb begin
      next_state    = S_FETCH;
      iord_c        = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      ir_write_c    = 1'b0;
      pc_en_c       = 1'b0;
      pc_src_c      = 2'b00;
      alu_src_a_c   = 1'b0;
      alu_src_b_c   = 2'b00;
      alu_control_c = 4'b0000;
      reg_dst_c     = 1'b0;
      mem_to_reg_c  = 1'b0;
      reg_write_c   = 1'b0;
      done_c        = 1'b0;
      illegal_c     = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_read_c    = 1'b1;
            alu_src_b_c   = 2'b01;
            alu_control_c = ALU_ADD;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_en_c    = 1'b1;
               next_state = S_DECODE;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded
            alu_src_b_c   = 2'b11;
            alu_control_c = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_ok(funct)) begin
                     next_state = S_EXEC;
                  end else begin
                     illegal_c  = 1'b1;
                     next_state = S_FETCH;
                  end
               end
               OP_BEQ:  next_state = S_BRANCH;
               OP_ADDI: next_state = S_ADDIEX;
               OP_J:    next_state = S_JUMP;
               default: begin
                  illegal_c  = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_c   = 1'b1;
            alu_src_b_c   = 2'b10;
            alu_control_c = ALU_ADD;
            if (opcode == OP_LW) begin
               next_state = S_MEMRD;
            end else if (opcode == OP_SW) begin
               next_state = S_MEMWR;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_MEMRD: begin
            iord_c     = 1'b1;
            mem_read_c = 1'b1;
            if (mem_ready) begin
               next_state = S_MEMWB;
            end else begin
               next_state = S_MEMRD;
            end
         end
         S_MEMWB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
            done_c       = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEMWR: begin
            iord_c      = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready) begin
               done_c     = 1'b1;
               next_state = S_FETCH;
            end else begin
               next_state = S_MEMWR;
            end
         end
         S_EXEC: begin
            alu_src_a_c   = 1'b1;
            alu_control_c = alu_from_funct(funct);
            next_state    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 1'b1;
            done_c      = 1'b1;
            next_state  = S_FETCH;
         end
         S_BRANCH: begin
            // Not-taken leaves PC+4 from FETCH in place
            alu_src_a_c   = 1'b1;
            alu_control_c = ALU_SUB;
            pc_src_c      = 2'b01;
            pc_en_c       = zero;
            done_c        = 1'b1;
            next_state    = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a_c   = 1'b1;
            alu_src_b_c   = 2'b10;
            alu_control_c = ALU_ADD;
            next_state    = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            done_c      = 1'b1;
            next_state  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_c   = 2'b10;
            pc_en_c    = 1'b1;
            done_c     = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state;
      end
   end

   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 32'd0;
      end else if (done_c) begin
         count_r <= count_r + 32'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Strobes are gated by rst_n so nothing fires while reset is held, even though FETCH is the reset state
   assign mem_read    = mem_read_c  & rst_n;
   assign mem_write   = mem_write_c & rst_n;
   assign ir_write    = ir_write_c  & rst_n;
   assign pc_en       = pc_en_c     & rst_n;
   assign reg_write   = reg_write_c & rst_n;
   assign instr_done  = done_c      & rst_n;
   assign illegal_op  = illegal_c   & rst_n;
   assign iord        = iord_c;
   assign pc_src      = pc_src_c;
   assign alu_src_a   = alu_src_a_c;
   assign alu_src_b   = alu_src_b_c;
   assign alu_control = alu_control_c;
   assign reg_dst     = reg_dst_c;
   assign mem_to_reg  = mem_to_reg_c;
   assign instr_count = count_r;
   assign state       = state_r;

   multicycle_mips_ctrl_chk u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_r),
      .iord      (iord),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .reg_write (reg_write)
   );

endmodule

// Property checker for the control FSM: legal states and consistent memory strobes.
module multicycle_mips_ctrl_chk (
   input logic       clk,
   input logic       rst_n,
   input logic [3:0] state,
   input logic       iord,
   input logic       mem_read,
   input logic       mem_write,
   input logic       reg_write
);

   // No write strobe or memory request while reset is held
   always_comb begin
      assert (rst_n || !(mem_read || mem_write || reg_write));
   end

   // Memory requests are exclusive, data writes use ALUOut, states stay in the decoded range
   always_ff @(posedge clk) begin
      assert (!(mem_read && mem_write));
      assert (!mem_write || iord);
      assert (!rst_n || (state < 4'd12));
   end

endmodule

// File: tb/tb_multicycle_mips_ctrl.sv
// Self-checking bench for multicycle_mips_ctrl: latency table, directed corner
// sequences and randomized instructions against a phase-list reference model.
module tb_multicycle_mips_ctrl;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        iord, mem_read, mem_write, ir_write, pc_en;
   logic [1:0]  pc_src, alu_src_b;
   logic        alu_src_a, reg_dst, mem_to_reg, reg_write;
   logic [3:0]  alu_control;
   logic        instr_done, illegal_op;
   logic [31:0] instr_count;
   logic [3:0]  state;

   multicycle_mips_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
      .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_count;

   // Observations collected by run_instr for the directed checks
   int          obs_cyc, obs_rw, obs_mw;
   logic [3:0]  obs_alu;
   logic        obs_regdst7, obs_pcen8, obs_mtr4;
   logic [1:0]  obs_pcsrc8;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each instruction is a list of phases (state code, waits on memory or not).
   // Called at a negedge with the DUT in FETCH; returns at a negedge with the DUT back in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm);
      int  code[5];
      bit  memp[5];
      int  n;
      bit  legal;
      bit  last;
      int  len;
      legal = 1'b1;
      for (int i = 0; i < 5; i++) begin
         code[i] = 0;
         memp[i] = 1'b0;
      end
      code[0] = 0; memp[0] = 1'b1;
      code[1] = 1;
      n = 2;
      if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                              fn == 6'b100101 || fn == 6'b101010)) begin
         code[2] = 6; code[3] = 7; n = 4;
      end else if (op == 6'b100011) begin
         code[2] = 2; code[3] = 3; memp[3] = 1'b1; code[4] = 4; n = 5;
      end else if (op == 6'b101011) begin
         code[2] = 2; code[3] = 5; memp[3] = 1'b1; n = 4;
      end else if (op == 6'b000100) begin
         code[2] = 8; n = 3;
      end else if (op == 6'b001000) begin
         code[2] = 9; code[3] = 10; n = 4;
      end else if (op == 6'b000010) begin
         code[2] = 11; n = 3;
      end else begin
         legal = 1'b0;
      end
      obs_cyc = 0; obs_rw = 0; obs_mw = 0;
      obs_alu = 4'hF; obs_regdst7 = 1'b0; obs_pcen8 = 1'b0; obs_mtr4 = 1'b0; obs_pcsrc8 = 2'b11;
      opcode = op; funct = fn; zero = z;
      for (int p = 0; p < n; p++) begin
         len = memp[p] ? (((p == 0) ? wf : wm) + 1) : 1;
         for (int k = 0; k < len; k++) begin
            mem_ready = memp[p] ? (k == len - 1) : 1'($urandom_range(0, 1));
            #1;
            last = (p == n - 1) && (k == len - 1);
            chk("state", 32'(state), 32'(code[p]));
            chk("instr_done", 32'(instr_done), 32'(legal && last));
            chk("illegal_op", 32'(illegal_op), 32'(!legal && last));
            if (memp[p]) begin
               if (code[p] == 5) chk("mem_write", 32'(mem_write), 32'd1);
               else              chk("mem_read", 32'(mem_read), 32'd1);
               chk("iord", 32'(iord), 32'(p != 0));
            end
            obs_cyc++;
            if (reg_write) obs_rw++;
            if (mem_write) obs_mw++;
            if (code[p] == 6) obs_alu = alu_control;
            if (code[p] == 7) obs_regdst7 = reg_dst;
            if (code[p] == 4) obs_mtr4 = mem_to_reg;
            if (code[p] == 8) begin
               obs_pcen8  = pc_en;
               obs_pcsrc8 = pc_src;
            end
            @(negedge clk);
         end
      end
      if (legal) exp_count = exp_count + 32'd1;
      chk("instr_count", instr_count, exp_count);
   endtask

   // Plain latency measurement with mem_ready held at 1, independent of the phase model
   task automatic measure(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          output int lat, output logic ill);
      bool_loop: begin end
      opcode = op; funct = fn; zero = z; mem_ready = 1'b1;
      lat = -1; ill = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (instr_done || illegal_op) begin
            lat = c + 1;
            ill = illegal_op;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         lat;
      logic       ill;
   } vec_t;

   vec_t tbl[11];
   int   lat;
   logic ill;
   logic [5:0] rops[11];
   logic [5:0] rfns[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 4, 1'b0};
      tbl[1]  = '{6'b000000, 6'b100100, 1'b0, 4, 1'b0};
      tbl[2]  = '{6'b000000, 6'b100101, 1'b0, 4, 1'b0};
      tbl[3]  = '{6'b100011, 6'b000000, 1'b0, 5, 1'b0};
      tbl[4]  = '{6'b101011, 6'b000000, 1'b0, 4, 1'b0};
      tbl[5]  = '{6'b001000, 6'b000000, 1'b0, 4, 1'b0};
      tbl[6]  = '{6'b000100, 6'b000000, 1'b1, 3, 1'b0};
      tbl[7]  = '{6'b000100, 6'b000000, 1'b0, 3, 1'b0};
      tbl[8]  = '{6'b000010, 6'b000000, 1'b0, 3, 1'b0};
      tbl[9]  = '{6'b111111, 6'b000000, 1'b0, 2, 1'b1};
      tbl[10] = '{6'b000000, 6'b000111, 1'b0, 2, 1'b1};
      for (int i = 0; i < 11; i++) begin
         rops[i] = tbl[i].op;
         rfns[i] = tbl[i].fn;
      end

      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      exp_count = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_count", instr_count, 32'd0);
      chk("reset_mem_read", 32'(mem_read), 32'd0);
      chk("reset_ir_write", 32'(ir_write), 32'd0);
      chk("reset_pc_en", 32'(pc_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first_fetch_mem_read", 32'(mem_read), 32'd1);
      chk("first_fetch_iord", 32'(iord), 32'd0);
      chk("first_fetch_alu_src_b", 32'(alu_src_b), 32'd1);
      @(negedge clk);
      // The sampled cycle above consumed a FETCH with mem_ready=1, so finish that instruction (LW)
      // is not possible here; re-align by letting the decode of opcode 0 funct 0 end as illegal.
      #1;
      chk("realign_illegal", 32'(illegal_op), 32'd1);
      @(negedge clk);

      // LW with no stalls
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
      chk("lw_cycles", 32'(obs_cyc), 32'd5);
      chk("lw_mem_to_reg", 32'(obs_mtr4), 32'd1);
      chk("lw_reg_write", 32'(obs_rw), 32'd1);
      chk("lw_count", instr_count, 32'd1);

      // R-type sub then slt
      run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
      chk("sub_alu", 32'(obs_alu), 32'h6);
      chk("sub_reg_dst", 32'(obs_regdst7), 32'd1);
      chk("sub_cycles", 32'(obs_cyc), 32'd4);
      run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
      chk("slt_alu", 32'(obs_alu), 32'h7);
      chk("slt_cycles", 32'(obs_cyc), 32'd4);

      // SW with three stall cycles in MEMWR
      run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);
      chk("sw_mem_write_cycles", 32'(obs_mw), 32'd4);
      chk("sw_reg_write", 32'(obs_rw), 32'd0);
      chk("sw_cycles", 32'(obs_cyc), 32'd7);

      // BEQ taken / not taken
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
      chk("beq_taken_pc_en", 32'(obs_pcen8), 32'd1);
      chk("beq_taken_pc_src", 32'(obs_pcsrc8), 32'd1);
      chk("beq_taken_cycles", 32'(obs_cyc), 32'd3);
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
      chk("beq_nt_pc_en", 32'(obs_pcen8), 32'd0);
      chk("beq_nt_cycles", 32'(obs_cyc), 32'd3);

      // Illegal opcode and illegal funct leave the count alone
      run_instr(6'b111111, 6'b000000, 1'b0, 1, 0);
      chk("illop_cycles", 32'(obs_cyc), 32'd3);
      run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
      chk("illfn_cycles", 32'(obs_cyc), 32'd2);

      // Latency table with mem_ready held high
      for (int i = 0; i < 11; i++) begin
         measure(tbl[i].op, tbl[i].fn, tbl[i].z, lat, ill);
         chk("tbl_latency", 32'(lat), 32'(tbl[i].lat));
         chk("tbl_illegal", 32'(ill), 32'(tbl[i].ill));
         if (!tbl[i].ill) exp_count = exp_count + 32'd1;
         chk("tbl_count", instr_count, exp_count);
      end

      // Reset in the middle of a load read
      opcode = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (state == 4'd3) break;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      chk("reach_memrd", 32'(state), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_mem_read", 32'(mem_read), 32'd0);
      chk("midrst_mem_write", 32'(mem_write), 32'd0);
      chk("midrst_reg_write", 32'(reg_write), 32'd0);
      chk("midrst_pc_en", 32'(pc_en), 32'd0);
      chk("midrst_instr_done", 32'(instr_done), 32'd0);
      chk("midrst_count", instr_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 32'd0;
      run_instr(6'b000010, 6'b000000, 1'b0, 2, 0);
      chk("post_rst_j_cycles", 32'(obs_cyc), 32'd5);

      // Counter wrap
      force dut.count_r = 32'hFFFF_FFFF;
      #1;
      release dut.count_r;
      #1;
      chk("preload_count", instr_count, 32'hFFFF_FFFF);
      exp_count = 32'hFFFF_FFFF;
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
      chk("wrap_count", instr_count, 32'd0);

      // Randomized instructions and stalls
      for (int r = 0; r < 40; r++) begin
         int idx;
         idx = int'($urandom_range(0, 10));
         run_instr(rops[idx], rfns[idx], 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
